// File: rtl/wave_logo_pkg.sv
// Shared constants, state type and wave helper
// for the wave-logo row reader.
package wave_logo_pkg;

  localparam int unsigned ROW_W    = 38;
  localparam int unsigned IDX_W    = 10;
  localparam int unsigned NUM_ROWS = 251;
  localparam int unsigned WAVE_P   = 16;
  localparam int unsigned PH_W     = $clog2(WAVE_P);
  localparam int unsigned COL_W    = $clog2(ROW_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT
  } state_t;

  // Triangle of period WAVE_P; upper half folds back via ~t.
  function automatic logic [PH_W-1:0] tri_amp(
    input logic [IDX_W-1:0] row,
    input logic [PH_W-1:0]  ph
  );
    logic [PH_W-1:0] t;
    t = row[PH_W-1:0] + ph;
    return t[PH_W-1] ? ~t : t;
  endfunction

endpackage

// File: rtl/row_rotator.sv
// Combinational barrel rotate-right of one logo row.
// One conditional stage per bit of the rotate amount.
module row_rotator
  import wave_logo_pkg::*;
(
  input  logic [ROW_W-1:0] d,
  input  logic [PH_W-1:0]  amt,
  output logic [ROW_W-1:0] q
);

  logic [ROW_W-1:0] w_stg [PH_W+1];

  assign w_stg[0] = d;

  for (genvar k = 0; k < PH_W; k++) begin : g_stg
    localparam int unsigned S = 2 ** k;
    assign w_stg[k+1] = amt[k]
      ? {w_stg[k][S-1:0], w_stg[k][ROW_W-1:S]}
      : w_stg[k];
  end

  assign q = w_stg[PH_W];

endmodule

// File: rtl/logo_row_streamer.sv
// Walks the logo ROM row by row, rotates each row by a
// triangle-wave offset and streams it out MSB first.
module logo_row_streamer
  import wave_logo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] rom_idx,
  input  logic [ROW_W-1:0] rom_data,
  output logic             px_data,
  output logic             px_valid,
  input  logic             px_ready,
  output logic             px_last_col,
  output logic             px_last_row,
  output logic             busy,
  output logic             frame_done,
  output logic [PH_W-1:0]  phase
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_shreg;
  logic [ROW_W-1:0] w_rot;
  logic [PH_W-1:0]  r_phase;
  logic [PH_W-1:0]  w_amp;
  logic             r_frame_done;
  logic             w_shift;
  logic             w_hs;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_row_end;

  assign w_shift    = (r_state == ST_SHIFT);
  assign w_last_col = w_shift &&
                      (r_col == COL_W'(ROW_W - 1));
  assign w_last_row = w_shift &&
                      (r_row == IDX_W'(NUM_ROWS - 1));
  assign w_hs       = w_shift && px_ready;
  assign w_row_end  = w_hs && w_last_col;
  assign w_amp      = tri_amp(r_row, r_phase);

  row_rotator u_rot (
    .d   (rom_data),
    .amt (w_amp),
    .q   (w_rot)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if (start) w_state_nxt = ST_FETCH;
      ST_FETCH:
        w_state_nxt = ST_SHIFT;
      ST_SHIFT:
        if (w_row_end)
          w_state_nxt = w_last_row ? ST_IDLE
                                   : ST_FETCH;
      default:
        w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row        <= '0;
      r_col        <= '0;
      r_shreg      <= '0;
      r_phase      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_state == ST_IDLE && start)
        r_row <= '0;
      // rom_data is only trusted during the fetch bubble
      if (r_state == ST_FETCH) begin
        r_shreg <= w_rot;
        r_col   <= '0;
      end
      if (w_hs) begin
        r_shreg <= {r_shreg[ROW_W-2:0], 1'b0};
        r_col   <= r_col + COL_W'(1);
      end
      if (w_row_end) begin
        if (w_last_row) begin
          r_phase      <= r_phase + PH_W'(1);
          r_frame_done <= 1'b1;
        end else begin
          r_row <= r_row + IDX_W'(1);
        end
      end
    end
  end

  assign rom_idx     = r_row;
  assign px_data     = w_shift & r_shreg[ROW_W-1];
  assign px_valid    = w_shift;
  assign px_last_col = w_last_col;
  assign px_last_row = w_last_row;
  assign busy        = (r_state != ST_IDLE);
  assign frame_done  = r_frame_done;
  assign phase       = r_phase;

endmodule
